sub_bytes_seq: RTL and testbench

Parametrised, sequential AES SubBytes/InvSubBytes engine for the AES-CTR datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per clock. It then holds the result on a valid/ready output. This lets area-constrained builds trade S-box count against latency, and gives the decrypt/key-schedule paths an inverse mode.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/sub_bytes_seq_if.sv | 34 +++
 rtl/sbox_dual.sv | 13 +
 rtl/sub_bytes_seq.sv | 118 +++++++++++
 tb/tb_sub_bytes_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and S-box tables.
// Byte 0 of the state sits in the top byte of the 128-bit word.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sb_state_e;

    // Bit offset of the least significant bit of byte idx.
    function automatic int byte_lsb(input int idx);
        return AES_STATE_W - 8 * (idx + 1);
    endfunction

    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

endpackage

// File: rtl/sub_bytes_seq_if.sv
// Block handshake bundle for the SubBytes engine.
// The master drives a state in and takes the substituted state out.
interface sub_bytes_seq_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] in_data;
    logic                   in_inv;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output in_inv,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_inv,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/sbox_dual.sv
// Single-byte AES S-box with selectable forward or inverse table.
// Purely combinational ROM lookup.
module sbox_dual
    import aes_pkg::*;
(
    input  logic [7:0] x,
    input  logic       inv,
    output logic [7:0] y
);

    assign y = inv ? SBOX_INV[x] : SBOX_FWD[x];

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential SubBytes/InvSubBytes: LANES bytes per cycle, MSB byte first.
// Result is held in a separate register so it only moves on completion.
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic          clk,
    input  logic          rst,
    sub_bytes_seq_if.slave bus
);

    localparam int BEATS = AES_BYTES / LANES;
    localparam int W     = LANES * 8;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_e state;
    sb_state_e state_n;

    logic [AES_STATE_W-1:0] st_q;
    logic [AES_STATE_W-1:0] st_d;
    logic [AES_STATE_W-1:0] out_q;
    logic                   mode_q;
    logic [CW-1:0]          cnt;
    logic                   load;
    logic                   last;
    logic [6:0]             lsb;
    logic [W-1:0]           win_in;
    logic [W-1:0]           win_out;

    assign last = (cnt == CW'(BEATS - 1));

    // Window of this beat: bytes cnt*LANES .. cnt*LANES+LANES-1.
    assign lsb    = 7'(byte_lsb(int'(cnt) * LANES + LANES - 1));
    assign win_in = st_q[lsb +: W];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        sbox_dual u_sbox (
            .x   (win_in[W-1-8*j -: 8]),
            .inv (mode_q),
            .y   (win_out[W-1-8*j -: 8])
        );
    end

    always_comb begin
        st_d          = st_q;
        st_d[lsb +: W] = win_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        load          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        load    = 1'b1;
                        state_n = BUSY;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= '0;
            out_q  <= '0;
            mode_q <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            st_q   <= bus.in_data;
            mode_q <= bus.in_inv;
            cnt    <= '0;
        end else if (state == BUSY) begin
            st_q <= st_d;
            cnt  <= last ? '0 : cnt + CW'(1);
            if (last) begin
                out_q <= st_d;
            end
        end
    end

    assign bus.out_data = out_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: all five LANES builds run side by side on
// shared stimulus, checked against a GF(2^8) arithmetic S-box model.
module tb_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iv = 1'b0;
    logic [127:0] id = '0;
    logic         inv = 1'b0;
    logic         ordy = 1'b1;

    logic [4:0]   ov;
    logic [4:0]   ir;
    logic [127:0] od [5];

    int total = 0;
    int bad   = 0;

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 5; k++) begin : g
        sub_bytes_seq_if bus ();
        assign bus.in_valid  = iv;
        assign bus.in_data   = id;
        assign bus.in_inv    = inv;
        assign bus.out_ready = ordy;
        assign ov[k] = bus.out_valid;
        assign ir[k] = bus.in_ready;
        assign od[k] = bus.out_data;
        sub_bytes_seq #(.LANES(1 << k)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int b = 1; b < 256; b++)
            if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
        return 8'h00;
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] x);
        logic [7:0] y = ginv(x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^
               {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic m);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b = d[127-8*i -: 8];
            r[127-8*i -: 8] = m ? inv_t[b] : fwd_t[b];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // One block into all builds; junk is presented every cycle afterwards.
    task automatic run_block(input string tag, input logic [127:0] d, input logic m);
        int           lat [5];
        logic [127:0] dat [5];
        logic [127:0] exp_d;
        exp_d = model(d, m);
        @(negedge clk);
        check($sformatf("%s idle_ready", tag), 128'(ir), 128'h1f);
        iv = 1'b1; id = d; inv = m; ordy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            lat[k] = 0;
            dat[k] = '0;
        end
        @(posedge clk); #1;
        for (int c = 1; c <= 20; c++) begin
            id  = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom);
            @(posedge clk); #1;
            for (int k = 0; k < 5; k++)
                if (ov[k] && lat[k] == 0) begin
                    lat[k] = c;
                    dat[k] = od[k];
                end
        end
        iv = 1'b0;
        repeat (20) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("%s lat L%0d", tag, 1 << k), 128'(lat[k]), 128'(16 >> k));
            check($sformatf("%s data L%0d", tag, 1 << k), dat[k], exp_d);
        end
    endtask

    typedef struct {
        logic [127:0] d;
        logic         m;
        logic [127:0] e;
    } vec_t;

    vec_t vecs [5];
    logic [127:0] ra, rb, rc;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) fwd_t[i] = sbox_math(8'(i));
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 1'b0,
                    128'h638293c31bfc33f5c4eeacea4bc12816};
        vecs[1] = '{128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1,
                    128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{128'h0, 1'b0, {16{8'h63}}};
        vecs[3] = '{128'h0, 1'b1, {16{8'h52}}};
        vecs[4] = '{{16{8'hff}}, 1'b0, {16{8'h16}}};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("reset valid L%0d", 1 << k), 128'(ov[k]), 128'h0);
            check($sformatf("reset data L%0d", 1 << k), od[k], 128'h0);
            check($sformatf("reset ready L%0d", 1 << k), 128'(ir[k]), 128'h1);
        end

        for (int v = 0; v < 5; v++) begin
            check($sformatf("table model v%0d", v), model(vecs[v].d, vecs[v].m), vecs[v].e);
            run_block($sformatf("vec%0d", v), vecs[v].d, vecs[v].m);
        end

        for (int n = 0; n < 20; n++)
            run_block($sformatf("rnd%0d", n),
                      {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));

        // Backpressure on the LANES=4 build.
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        iv = 1'b1; id = ra; inv = 1'b0; ordy = 1'b0;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp done valid", 128'(ov[2]), 128'h1);
        check("bp done data", od[2], model(ra, 1'b0));
        iv = 1'b1; id = rb; inv = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold valid c%0d", c), 128'(ov[2]), 128'h1);
            check($sformatf("bp hold ready c%0d", c), 128'(ir[2]), 128'h0);
            check($sformatf("bp hold data c%0d", c), od[2], model(ra, 1'b0));
        end
        ordy = 1'b1;
        #1;
        check("bp release ready", 128'(ir[2]), 128'h1);
        @(posedge clk); #1;
        iv = 1'b0; id = '0; inv = 1'b0;
        check("bp reload valid", 128'(ov[2]), 128'h0);
        check("bp reload data held", od[2], model(ra, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("bp second early", 128'(ov[2]), 128'h0);
        @(posedge clk); #1;
        check("bp second valid", 128'(ov[2]), 128'h1);
        check("bp second data", od[2], model(rb, 1'b1));
        repeat (40) @(posedge clk);

        // Reset in the middle of a LANES=4 block.
        rc = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        iv = 1'b1; id = rc; inv = 1'b0;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst mid valid", 128'(ov[2]), 128'h0);
        check("rst mid data", od[2], 128'h0);
        check("rst mid ready", 128'(ir[2]), 128'h1);
        repeat (2) @(posedge clk);
        check("rst quiet valid", 128'(ov), 128'h0);
        run_block("after_rst", ~rc, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
